// File: rtl/peri_pdm_stereo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : peri_pdm_stereo_ctrl
// Brief    : Wishbone-controlled stereo PDM microphone front end. Generates a
//            shared mic clock, counts ones per channel over a decimation
//            window and queues tagged counts in an 8-deep FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module peri_pdm_stereo_ctrl #(
    parameter int ClkHz    = 48_000_000,
    parameter int MicHz    = 3_000_000,
    parameter int DecimLen = 128
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wb_we_i,
    input  logic [1:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_stb_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       mic_clk_o,
    input  logic       mic_data_i,
    output logic       irq_o
);

    localparam logic [1:0] c_adr_ctrl   = 2'd0;
    localparam logic [1:0] c_adr_div    = 2'd1;
    localparam logic [1:0] c_adr_status = 2'd2;
    localparam logic [1:0] c_adr_data   = 2'd3;
    localparam logic [7:0] c_div_reset  = 8'(ClkHz / MicHz / 2 - 1);
    localparam logic [7:0] c_last_edge  = 8'(DecimLen - 1);
    localparam logic [3:0] c_depth      = 4'd8;

    logic       r_enable;
    logic       r_irq_en;
    logic [7:0] r_div;
    logic [7:0] r_cnt;
    logic       r_mic_clk;
    logic [7:0] r_acc0;
    logic [7:0] r_acc1;
    logic [7:0] r_edges0;
    logic [7:0] r_edges1;
    logic [8:0] r_mem [0:7];
    logic [2:0] r_wr_ptr;
    logic [2:0] r_rd_ptr;
    logic [3:0] r_level;
    logic       r_ovf;

    logic       w_wr;
    logic       w_rd;
    logic       w_ctrl_wr;
    logic       w_run;
    logic       w_tick;
    logic       w_edge_ch;
    logic [7:0] w_acc_sel;
    logic [7:0] w_edges_sel;
    logic [7:0] w_sum;
    logic       w_push;
    logic [8:0] w_push_data;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_accept;
    logic [8:0] w_head;

    assign w_wr      = wb_stb_i & wb_we_i;
    assign w_rd      = wb_stb_i & ~wb_we_i;
    assign w_ctrl_wr = w_wr && (wb_adr_i == c_adr_ctrl);

    // A write clearing enable stops the clock on the same edge, so mic_clk_o
    // is already low in the cycle after the write.
    assign w_run  = r_enable && !(w_ctrl_wr && !wb_dat_i[0]);
    assign w_tick = w_run && (r_cnt == 8'd0);

    // Toggle from high is a falling edge (channel 0), from low a rising edge (channel 1).
    assign w_edge_ch   = ~r_mic_clk;
    assign w_acc_sel   = w_edge_ch ? r_acc1 : r_acc0;
    assign w_edges_sel = w_edge_ch ? r_edges1 : r_edges0;
    assign w_sum       = w_acc_sel + {7'd0, mic_data_i};
    assign w_push      = w_tick && (w_edges_sel == c_last_edge);
    assign w_push_data = {w_edge_ch, w_sum};

    assign w_empty  = (r_level == 4'd0);
    assign w_full   = (r_level == c_depth);
    assign w_pop    = w_rd && (wb_adr_i == c_adr_data) && !w_empty;
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_enable  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_div     <= c_div_reset;
            r_cnt     <= c_div_reset;
            r_mic_clk <= 1'b0;
            r_acc0    <= 8'd0;
            r_acc1    <= 8'd0;
            r_edges0  <= 8'd0;
            r_edges1  <= 8'd0;
            r_wr_ptr  <= 3'd0;
            r_rd_ptr  <= 3'd0;
            r_level   <= 4'd0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= wb_dat_i[0];
                r_irq_en <= wb_dat_i[1];
            end
            if (w_wr && (wb_adr_i == c_adr_div)) begin
                r_div <= wb_dat_i;
            end

            if (!w_run) begin
                r_mic_clk <= 1'b0;
                r_cnt     <= r_div;
                r_acc0    <= 8'd0;
                r_acc1    <= 8'd0;
                r_edges0  <= 8'd0;
                r_edges1  <= 8'd0;
            end else if (w_tick) begin
                r_mic_clk <= ~r_mic_clk;
                r_cnt     <= r_div;
                if (w_edge_ch) begin
                    r_acc1   <= w_push ? 8'd0 : w_sum;
                    r_edges1 <= w_push ? 8'd0 : r_edges1 + 8'd1;
                end else begin
                    r_acc0   <= w_push ? 8'd0 : w_sum;
                    r_edges0 <= w_push ? 8'd0 : r_edges0 + 8'd1;
                end
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end

            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 3'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 3'd1;
            end
            if (w_accept && !w_pop) begin
                r_level <= r_level + 4'd1;
            end else if (!w_accept && w_pop) begin
                r_level <= r_level - 4'd1;
            end

            // Overflow wins over a simultaneous clear so no drop goes unreported.
            if (w_push && !w_accept) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (wb_adr_i == c_adr_status) && wb_dat_i[6]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_accept) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_comb begin
        wb_dat_o = 8'd0;
        case (wb_adr_i)
            c_adr_ctrl:   wb_dat_o = {6'd0, r_irq_en, r_enable};
            c_adr_div:    wb_dat_o = r_div;
            c_adr_status: wb_dat_o = {r_ovf, w_head[8] & ~w_empty, r_level, 1'b0, ~w_empty};
            c_adr_data:   wb_dat_o = w_empty ? 8'd0 : w_head[7:0];
            default:      wb_dat_o = 8'd0;
        endcase
    end

    assign wb_ack_o  = wb_stb_i;
    assign mic_clk_o = r_mic_clk;
    assign irq_o     = r_irq_en & ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_peri_pdm_stereo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_peri_pdm_stereo_ctrl
// Brief    : Self-checking bench; expected FIFO contents are derived from the
//            mic-clock edge timetable and the recorded data line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peri_pdm_stereo_ctrl;

    localparam int c_decim = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_we;
    logic [1:0] wb_adr;
    logic [7:0] wb_dat_w;
    logic       wb_stb;
    logic [7:0] wb_dat_r;
    logic       wb_ack;
    logic       mic_clk;
    logic       mic_data;
    logic       irq;

    int         cyc;
    int         mode;
    int         n_checks;
    int         n_fail;
    logic       hist [0:65535];
    logic [8:0] exp_q [$];
    logic       exp_ovf;

    always #5 clk = ~clk;

    peri_pdm_stereo_ctrl #(
        .ClkHz    (48_000_000),
        .MicHz    (3_000_000),
        .DecimLen (c_decim)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb_we_i    (wb_we),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat_w),
        .wb_stb_i   (wb_stb),
        .wb_dat_o   (wb_dat_r),
        .wb_ack_o   (wb_ack),
        .mic_clk_o  (mic_clk),
        .mic_data_i (mic_data),
        .irq_o      (irq)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Mode 0: random data, 1: constant ones, 2: ones only before a falling edge.
    task automatic tick();
        logic b;
        case (mode)
            0:       b = 1'($urandom_range(0, 1));
            1:       b = 1'b1;
            default: b = mic_clk;
        endcase
        mic_data = b;
        hist[cyc + 1] = b;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
        wb_stb = 1'b1; wb_we = 1'b1; wb_adr = a; wb_dat_w = d;
        tick();
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [7:0] d);
        wb_stb = 1'b1; wb_we = 1'b0; wb_adr = a;
        #1;
        d = wb_dat_r;
        tick();
        wb_stb = 1'b0;
    endtask

    // Walk the mic-clock toggles of one enabled interval (toggle k at e0+k*(div+1),
    // odd k rising -> ch1) and feed completed windows into the expected FIFO.
    task automatic model_window(input int e0, input int e1, input int div,
                                input int pop_t, output logic [8:0] popped);
        int acc [2];
        int cnt [2];
        acc = '{0, 0};
        cnt = '{0, 0};
        popped = 9'd0;
        for (int k = 1; e0 + k * (div + 1) < e1; k++) begin
            int t;
            int ch;
            logic [8:0] e;
            t = e0 + k * (div + 1);
            ch = k % 2;
            acc[ch] += int'(hist[t]);
            cnt[ch]++;
            if (cnt[ch] == c_decim) begin
                e = {ch[0], acc[ch][7:0]};
                if (t == pop_t) begin
                    popped = exp_q.pop_front();
                    exp_q.push_back(e);
                end else if (exp_q.size() == 8) begin
                    exp_ovf = 1'b1;
                end else begin
                    exp_q.push_back(e);
                end
                acc[ch] = 0;
                cnt[ch] = 0;
            end
        end
    endtask

    function automatic logic [7:0] exp_status();
        int   n;
        logic hc;
        n  = exp_q.size();
        hc = (n != 0) ? exp_q[0][8] : 1'b0;
        return {exp_ovf, hc, 4'(n), 1'b0, n != 0};
    endfunction

    task automatic run_enabled(input int n, input logic irq_en, output int e0, output int e1);
        wb_write(2'd0, {6'd0, irq_en, 1'b1});
        e0 = cyc;
        repeat (n) tick();
        wb_write(2'd0, {6'd0, irq_en, 1'b0});
        e1 = cyc;
    endtask

    task automatic drain();
        logic [7:0] d;
        logic [7:0] s;
        logic [8:0] e;
        wb_read(2'd2, s);
        n_checks++;
        if (s !== exp_status()) begin
            n_fail++;
            $display("FAIL drain_status_pre: got 0x%02h expected 0x%02h", s, exp_status());
        end
        while (exp_q.size() != 0) begin
            wb_read(2'd2, s);
            n_checks++;
            if (s !== exp_status()) begin
                n_fail++;
                $display("FAIL drain_status: got 0x%02h expected 0x%02h", s, exp_status());
            end
            e = exp_q.pop_front();
            wb_read(2'd3, d);
            n_checks++;
            if (d !== e[7:0]) begin
                n_fail++;
                $display("FAIL drain_data: got 0x%02h expected 0x%02h (ch%0d)", d, e[7:0], e[8]);
            end
        end
        wb_read(2'd3, d);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL drain_empty_data: got 0x%02h expected 0x00", d);
        end
        wb_write(2'd2, 8'h40);
        exp_ovf = 1'b0;
        wb_read(2'd2, s);
        n_checks++;
        if (s !== 8'h00) begin
            n_fail++;
            $display("FAIL drain_status_post: got 0x%02h expected 0x00", s);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        mode = 0;
        rst = 1'b1;
        wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 2'd1; wb_dat_w = 8'h55;
        repeat (3) tick();
        wb_stb = 1'b0; wb_we = 1'b0;
        rst = 1'b0;
        n_checks++;
        if (mic_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mic_clk: got %b expected 0", mic_clk);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        wb_read(2'd0, d);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got 0x%02h expected 0x00", d);
        end
        wb_read(2'd1, d);
        n_checks++;
        if (d !== 8'h07) begin
            n_fail++;
            $display("FAIL reset_div: got 0x%02h expected 0x07", d);
        end
        wb_read(2'd2, d);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_status: got 0x%02h expected 0x00", d);
        end
        wb_read(2'd3, d);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got 0x%02h expected 0x00", d);
        end
        wb_read(2'd2, d);
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_status_after_data: got 0x%02h expected 0x00", d);
        end
    endtask

    task automatic test_basic();
        int         e0;
        int         e1;
        int         rise [$];
        logic       prev;
        logic [7:0] s;
        logic [8:0] unused;
        mode = 1;
        wb_write(2'd1, 8'd1);
        wb_write(2'd0, 8'h01);
        e0 = cyc;
        prev = mic_clk;
        repeat (17) begin
            tick();
            if (mic_clk && !prev) rise.push_back(cyc);
            prev = mic_clk;
        end
        n_checks++;
        if (rise.size() < 2 || rise[0] != e0 + 2) begin
            n_fail++;
            $display("FAIL basic_first_rise: got %0d rises, first at +%0d expected +2",
                     rise.size(), rise.size() > 0 ? rise[0] - e0 : -1);
        end
        n_checks++;
        if (rise.size() < 2 || rise[1] - rise[0] != 4) begin
            n_fail++;
            $display("FAIL basic_period: got %0d expected 4", rise.size() < 2 ? -1 : rise[1] - rise[0]);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_irq_masked: got %b expected 0", irq);
        end
        wb_write(2'd0, 8'h03);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_irq: got %b expected 1", irq);
        end
        wb_write(2'd0, 8'h02);
        e1 = cyc;
        model_window(e0, e1, 1, -1, unused);
        wb_read(2'd2, s);
        n_checks++;
        if (s !== 8'h49) begin
            n_fail++;
            $display("FAIL basic_status: got 0x%02h expected 0x49", s);
        end
        drain();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_irq_empty: got %b expected 0", irq);
        end
        wb_write(2'd0, 8'h00);
    endtask

    task automatic test_ch0_only();
        int         e0;
        int         e1;
        logic [8:0] unused;
        mode = 2;
        run_enabled(40, 1'b0, e0, e1);
        model_window(e0, e1, 1, -1, unused);
        drain();
    endtask

    task automatic test_overflow();
        int         e0;
        int         e1;
        logic [7:0] s;
        logic [8:0] unused;
        mode = 1;
        wb_write(2'd1, 8'd0);
        run_enabled(39, 1'b0, e0, e1);
        model_window(e0, e1, 0, -1, unused);
        wb_read(2'd2, s);
        n_checks++;
        if (s[7] !== 1'b1 || s[5:2] !== 4'd8) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%b level=%0d expected ovf=1 level=8", s[7], s[5:2]);
        end
        wb_write(2'd2, 8'h40);
        exp_ovf = 1'b0;
        wb_read(2'd2, s);
        n_checks++;
        if (s !== exp_status() || s[7] !== 1'b0 || s[5:2] !== 4'd8) begin
            n_fail++;
            $display("FAIL ovf_clear: got 0x%02h expected 0x%02h", s, exp_status());
        end
        drain();
    endtask

    task automatic test_push_pop_full();
        int         e0;
        int         e1;
        logic [7:0] d;
        logic [7:0] s;
        logic [8:0] popped;
        mode = 1;
        wb_write(2'd0, 8'h01);
        e0 = cyc;
        repeat (38) tick();
        wb_read(2'd3, d);
        wb_write(2'd0, 8'h00);
        e1 = cyc;
        model_window(e0, e1, 0, e0 + 39, popped);
        n_checks++;
        if (d !== popped[7:0]) begin
            n_fail++;
            $display("FAIL pp_read: got 0x%02h expected 0x%02h", d, popped[7:0]);
        end
        wb_read(2'd2, s);
        n_checks++;
        if (s[7] !== 1'b0 || s[5:2] !== 4'd8) begin
            n_fail++;
            $display("FAIL pp_status: got ovf=%b level=%0d expected ovf=0 level=8", s[7], s[5:2]);
        end
        drain();
    endtask

    task automatic test_disable_mid();
        int         e0;
        int         e1;
        logic [8:0] unused;
        mode = 1;
        wb_write(2'd1, 8'd1);
        wb_write(2'd0, 8'h01);
        e0 = cyc;
        repeat (19) tick();
        n_checks++;
        if (mic_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_clk_high: got %b expected 1", mic_clk);
        end
        wb_write(2'd0, 8'h00);
        e1 = cyc;
        n_checks++;
        if (mic_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_clk_low: got %b expected 0", mic_clk);
        end
        model_window(e0, e1, 1, -1, unused);
        repeat (3) tick();
        run_enabled(17, 1'b0, e0, e1);
        model_window(e0, e1, 1, -1, unused);
        drain();
    endtask

    task automatic test_random();
        int         e0;
        int         e1;
        int         div;
        logic [8:0] unused;
        for (int it = 0; it < 5; it++) begin
            div = $urandom_range(0, 3);
            mode = 0;
            wb_write(2'd1, 8'(div));
            run_enabled($urandom_range(20, 60), 1'b0, e0, e1);
            model_window(e0, e1, div, -1, unused);
            drain();
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_we = 1'b0; wb_adr = 2'd0; wb_dat_w = 8'd0; wb_stb = 1'b0;
        mic_data = 1'b0;
        cyc = 0; mode = 0; n_checks = 0; n_fail = 0; exp_ovf = 1'b0;
        test_reset();
        test_basic();
        test_ch0_only();
        test_overflow();
        test_push_pop_full();
        test_disable_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
